ste_joypad_ports: RTL and testbench
===================================

# ste_joypad_ports

Parametrised Atari STE enhanced-joystick/paddle/light-pen register block for the MiST ST core, mapped in the $FF92xx I/O window. Samples active-high pad, paddle and light-pen data from the IO controller, synchronises and debounces the digital lines, and presents STE-compatible active-low registers to the CPU bus. The direction register is writable and acts as an open-collector output latch for team-tap style adapters. Paddle values and light-pen position are snapshotted so that CPU reads are coherent.

## Interface
- NUM_PORTS, 2: enhanced ports implemented, 1..4; 4 direction bits and 1 fire bit per port.
- NUM_PADDLES, 4: paddle channels, 0..4; 8 bits each.
- DEBOUNCE_CYCLES, 1024: consecutive stable clk cycles before a fire/direction bit changes.
- SYNC_STAGES, 2: synchroniser flops on every external input bit, at least 2.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- din  in  16  CPU write data.
- sel  in  1  block select; one cycle-qualified bus access.
- addr  in  5  word index within $FF9200–$FF923E.
- uds, lds  in  1 each  byte enables: high byte, low byte.
- rw  in  1  1 = read, 0 = write.
- dout  out  16  registered read data.
- joy_dir  in  4*NUM_PORTS  direction inputs, active-high; port p uses bits [4p+3:4p], order up,down,left,right.
- joy_fire  in  NUM_PORTS  fire buttons, active-high.
- paddle  in  8*NUM_PADDLES  paddle positions.
- vsync  in  1  frame strobe, same clock domain.
- lp_trig  in  1  light-pen trigger, asynchronous.
- beam_x, beam_y  in  10 each  current video beam position.
- joy_out  out  16  direction output latch, active-low.

## Operation
- Register map, by word index: 0x00 fire: bits[NUM_PORTS-1:0] = ~fire_db, all other bits 1. 0x01 direction: ~dir_db & joy_out, unimplemented bits 1. 0x08+n paddle n, low byte: snapshot, high byte 0. 0x10 light-pen X: {6'b0, lp_x}. 0x11 light-pen Y: {6'b0, lp_y}.
- Any other index, or a paddle index ≥ NUM_PADDLES, reads 0x0000.
- Writes: only index 0x01 is writable. uds updates joy_out[15:8] and lds updates joy_out[7:0]. All other writes are ignored.
- Debounce, per bit: synchronised value compared against the debounced value. On mismatch, the counter increments. The debounced bit flips when the counter reaches DEBOUNCE_CYCLES−1 with the mismatch still present. Any match clears the counter.
- Paddle snapshot: on the rising edge of vsync (registered compare), all paddle inputs are copied into snapshot registers.
- Light pen, two states:
  - ARMED: on a synchronised rising edge of lp_trig, latch beam_x and beam_y into lp_x and lp_y, then go to HELD.
  - HELD: ignore further triggers; the vsync rising edge returns to ARMED.
  - Reset state is ARMED.

## Timing
- Reset (reset=0 at a clk edge): dout=0x0000, joy_out=0xFFFF, debounced bits=0 (released), counters=0, snapshots=0, lp_x=lp_y=0, light pen in ARMED, synchroniser flops=0.
- Read latency: 1 cycle. With sel && rw at edge N, dout is valid after edge N and holds until the next edge. When sel=0 or rw=0, dout returns to 0x0000 at the next edge.
- Write takes effect at the edge where sel && !rw. joy_out and the direction readback reflect it from the next cycle.
- Input to register latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles for a clean step.
- lp_trig to latch: SYNC_STAGES+1 cycles. The beam position sampled is the value at the edge-detect cycle.
- vsync edge coinciding with an lp_trig edge: the vsync transition to ARMED has priority, and the trigger in that cycle is dropped.
- Read of a paddle in the same cycle as a snapshot returns the old value.
- Reset mid-operation clears everything at that edge regardless of bus activity.

## Structure
- Package ste_joy_pkg:
  - register index constants: REG_FIRE, REG_DIR, REG_PADDLE0, REG_LPX, REG_LPY;
  - lp state enum {LP_ARMED, LP_HELD};
  - beam width constant, 10.
- Sub-module ste_joy_debounce (SYNC_STAGES, DEBOUNCE_CYCLES; clk, reset, in, out):
  - contains the synchroniser and debouncer;
  - instantiated for each of the 5*NUM_PORTS digital bits.
- The light-pen trigger uses a synchroniser and edge detect only, with no debounce.

## Test plan
- Reset, then read 0x00 and 0x01 with NUM_PORTS=2 -> 0xFFFF and 0xFFFF one cycle after sel; joy_out=0xFFFF.
- Set joy_fire[1]=1 for DEBOUNCE_CYCLES+SYNC_STAGES cycles, then read 0x00 -> 0xFFFD. A 10-cycle glitch on joy_fire[0] leaves 0xFFFF.
- Write 0x00F0 to 0x01 with lds only, then read -> 0xFFF0 and joy_out=0xFFF0. A subsequent write with uds only, din=0x0F00, gives joy_out=0x0FF0.
- Set paddle[7:0]=0x5A: reading 0x08 before vsync returns 0x0000. After a vsync rising edge it returns 0x005A. Changing paddle to 0x11 without vsync still reads 0x005A.
- Pulse lp_trig with beam=(123,45), then pulse again at beam=(200,99) before vsync -> 0x10 reads 0x007B and 0x11 reads 0x002D. After vsync and a new trigger, the new values are latched.
- Assert reset mid-read with fire and paddle state set -> dout=0x0000 next cycle and all registers return to their reset values.

Source files
------------

// File: rtl/ste_joy_pkg.sv
// ste_joy_pkg: register indices, light-pen states and beam width for the STE joypad block
package ste_joy_pkg;
  localparam logic [4:0] REG_FIRE    = 5'h00;
  localparam logic [4:0] REG_DIR     = 5'h01;
  localparam logic [4:0] REG_PADDLE0 = 5'h08;
  localparam logic [4:0] REG_LPX     = 5'h10;
  localparam logic [4:0] REG_LPY     = 5'h11;
  localparam int BEAM_W = 10;
  typedef enum logic {LP_ARMED, LP_HELD} lp_state_t;
endpackage

// File: rtl/ste_joy_debounce.sv
// ste_joy_debounce: input synchroniser followed by a stable-count debouncer
module ste_joy_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync <= '0;
      cnt  <= '0;
      out  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
      if (sync[SYNC_STAGES-1] == out) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        out <= sync[SYNC_STAGES-1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ste_joypad_ports.sv
// ste_joypad_ports: STE enhanced joystick, paddle and light-pen registers at $FF92xx
module ste_joypad_ports
  import ste_joy_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int NUM_PADDLES = 4,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic [15:0] din,
  input  logic sel,
  input  logic [4:0] addr,
  input  logic uds,
  input  logic lds,
  input  logic rw,
  output logic [15:0] dout,
  input  logic [4*NUM_PORTS-1:0] joy_dir,
  input  logic [NUM_PORTS-1:0] joy_fire,
  input  logic [8*NUM_PADDLES-1:0] paddle,
  input  logic vsync,
  input  logic lp_trig,
  input  logic [BEAM_W-1:0] beam_x,
  input  logic [BEAM_W-1:0] beam_y,
  output logic [15:0] joy_out
);
  localparam int NB = 5 * NUM_PORTS;
  logic [NB-1:0] raw, db;
  logic [4*NUM_PORTS-1:0] dir_db;
  logic [NUM_PORTS-1:0] fire_db;
  logic [8*NUM_PADDLES-1:0] snap;
  logic [BEAM_W-1:0] lp_x, lp_y;
  logic [SYNC_STAGES:0] lp_s;
  logic vsync_q, vs_rise, lp_rise;
  lp_state_t lp_state;
  logic [15:0] fire_rd, dir_rd, pad_rd, rdata;
  assign raw = {joy_fire, joy_dir};
  assign dir_db = db[4*NUM_PORTS-1:0];
  assign fire_db = db[NB-1:4*NUM_PORTS];
  for (genvar g = 0; g < NB; g++) begin : g_db
    ste_joy_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .in(raw[g]), .out(db[g])
    );
  end
  assign vs_rise = vsync & ~vsync_q;
  assign lp_rise = lp_s[SYNC_STAGES-1] & ~lp_s[SYNC_STAGES];
  always_comb begin
    fire_rd = '1;
    fire_rd[NUM_PORTS-1:0] = ~fire_db;
    dir_rd = '1;
    dir_rd[4*NUM_PORTS-1:0] = ~dir_db & joy_out[4*NUM_PORTS-1:0];
    pad_rd = '0;
    for (int i = 0; i < NUM_PADDLES; i++)
      if (addr == REG_PADDLE0 + 5'(i)) pad_rd = {8'h00, snap[8*i +: 8]};
    rdata = addr == REG_FIRE ? fire_rd :
            addr == REG_DIR  ? dir_rd :
            addr == REG_LPX  ? {6'b0, lp_x} :
            addr == REG_LPY  ? {6'b0, lp_y} : pad_rd;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout     <= '0;
      joy_out  <= '1;
      snap     <= '0;
      vsync_q  <= 1'b0;
      lp_s     <= '0;
      lp_x     <= '0;
      lp_y     <= '0;
      lp_state <= LP_ARMED;
    end else begin
      dout    <= (sel && rw) ? rdata : 16'h0000;
      vsync_q <= vsync;
      lp_s    <= {lp_s[SYNC_STAGES-1:0], lp_trig};
      if (sel && !rw && addr == REG_DIR) begin
        if (uds) joy_out[15:8] <= din[15:8];
        if (lds) joy_out[7:0] <= din[7:0];
      end
      if (vs_rise) snap <= paddle;
      // a vsync edge re-arms and swallows a trigger arriving in the same cycle
      if (vs_rise) lp_state <= LP_ARMED;
      else if (lp_state == LP_ARMED && lp_rise) begin
        lp_x     <= beam_x;
        lp_y     <= beam_y;
        lp_state <= LP_HELD;
      end
    end
  end
endmodule

// File: tb/tb_ste_joypad_ports.sv
// tb_ste_joypad_ports: directed checks of the STE joypad register block
module tb_ste_joypad_ports;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] din = '0;
  logic sel = 1'b0;
  logic [4:0] addr = '0;
  logic uds = 1'b0, lds = 1'b0, rw = 1'b1;
  logic [15:0] dout, joy_out;
  logic [7:0] joy_dir = '0;
  logic [1:0] joy_fire = '0;
  logic [31:0] paddle = '0;
  logic vsync = 1'b0, lp_trig = 1'b0;
  logic [9:0] beam_x = '0, beam_y = '0;
  int total = 0, bad = 0;
  ste_joypad_ports dut (
    .clk(clk), .reset(reset), .din(din), .sel(sel), .addr(addr), .uds(uds), .lds(lds),
    .rw(rw), .dout(dout), .joy_dir(joy_dir), .joy_fire(joy_fire), .paddle(paddle),
    .vsync(vsync), .lp_trig(lp_trig), .beam_x(beam_x), .beam_y(beam_y), .joy_out(joy_out)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rd(input logic [4:0] a);
    sel = 1'b1; rw = 1'b1; addr = a;
    tick();
    sel = 1'b0;
  endtask
  task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic u, input logic l);
    sel = 1'b1; rw = 1'b0; addr = a; din = d; uds = u; lds = l;
    tick();
    sel = 1'b0; rw = 1'b1; uds = 1'b0; lds = 1'b0;
  endtask
  task automatic lp_pulse();
    lp_trig = 1'b1;
    repeat (3) tick();
    lp_trig = 1'b0;
    repeat (4) tick();
  endtask
  task automatic vs_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_dout", dout, 16'h0000);
    chk("rst_joy_out", joy_out, 16'hFFFF);
    reset = 1'b1;
    rd(5'h00); chk("fire_idle", dout, 16'hFFFF);
    rd(5'h01); chk("dir_idle", dout, 16'hFFFF);
    tick(); chk("dout_idle_zero", dout, 16'h0000);
    joy_fire[0] = 1'b1;
    repeat (10) tick();
    joy_fire[0] = 1'b0;
    repeat (1100) tick();
    rd(5'h00); chk("fire_glitch", dout, 16'hFFFF);
    joy_fire[1] = 1'b1; joy_dir[0] = 1'b1;
    repeat (1025) tick();
    rd(5'h00); chk("fire_one_early", dout, 16'hFFFF);
    rd(5'h00); chk("fire1_db", dout, 16'hFFFD);
    rd(5'h01); chk("dir0_db", dout, 16'hFFFE);
    wr(5'h01, 16'h00F0, 1'b0, 1'b1); chk("wr_lds_joy_out", joy_out, 16'hFFF0);
    chk("wr_dout_zero", dout, 16'h0000);
    rd(5'h01); chk("dir_after_lds", dout, 16'hFFF0);
    wr(5'h01, 16'h0F00, 1'b1, 1'b0); chk("wr_uds_joy_out", joy_out, 16'h0FF0);
    wr(5'h00, 16'h0000, 1'b1, 1'b1); chk("wr_ignored", joy_out, 16'h0FF0);
    rd(5'h01); chk("dir_unimpl_ones", dout, 16'hFFF0);
    paddle[7:0] = 8'h5A; paddle[15:8] = 8'h33;
    rd(5'h08); chk("pad0_pre_vs", dout, 16'h0000);
    vs_pulse();
    rd(5'h08); chk("pad0_snap", dout, 16'h005A);
    rd(5'h09); chk("pad1_snap", dout, 16'h0033);
    rd(5'h0C); chk("pad_oob", dout, 16'h0000);
    rd(5'h05); chk("unmapped", dout, 16'h0000);
    paddle[7:0] = 8'h11;
    rd(5'h08); chk("pad0_no_vs", dout, 16'h005A);
    vsync = 1'b1;
    rd(5'h08); chk("pad0_same_cycle", dout, 16'h005A);
    vsync = 1'b0;
    rd(5'h08); chk("pad0_new", dout, 16'h0011);
    beam_x = 10'd123; beam_y = 10'd45;
    lp_pulse();
    beam_x = 10'd200; beam_y = 10'd99;
    lp_pulse();
    rd(5'h10); chk("lpx_held", dout, 16'h007B);
    rd(5'h11); chk("lpy_held", dout, 16'h002D);
    vs_pulse();
    beam_x = 10'd300; beam_y = 10'd500;
    lp_pulse();
    rd(5'h10); chk("lpx_rearm", dout, 16'h012C);
    rd(5'h11); chk("lpy_rearm", dout, 16'h01F4);
    vs_pulse();
    lp_pulse();
    beam_x = 10'd1; beam_y = 10'd2;
    lp_trig = 1'b1;
    repeat (2) tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0; lp_trig = 1'b0;
    repeat (4) tick();
    rd(5'h10); chk("lpx_vs_priority", dout, 16'h012C);
    sel = 1'b1; rw = 1'b1; addr = 5'h00; reset = 1'b0;
    tick();
    sel = 1'b0;
    chk("rst_mid_dout", dout, 16'h0000);
    chk("rst_mid_joy_out", joy_out, 16'hFFFF);
    reset = 1'b1;
    rd(5'h00); chk("rst_fire", dout, 16'hFFFF);
    rd(5'h01); chk("rst_dir", dout, 16'hFFFF);
    rd(5'h08); chk("rst_pad0", dout, 16'h0000);
    rd(5'h10); chk("rst_lpx", dout, 16'h0000);
    rd(5'h11); chk("rst_lpy", dout, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
